// File: rtl/tone_arbiter.sv
// Piezo buzzer arbiter. Game sound events become pending requests, and the buzzer
// is granted by fixed priority with preemption. It plays timed square-wave tones.
module tone_arbiter #(
  parameter int unsigned TICK_CYCLES = 25_175,
  parameter int unsigned PDL_HALF    = 28_608,
  parameter int unsigned WALL_HALF   = 57_216,
  parameter int unsigned SCORE_HALF  = 14_304,
  parameter int unsigned OVER_HALF0  = 19_072,
  parameter int unsigned OVER_HALF1  = 28_608,
  parameter int unsigned OVER_HALF2  = 57_216,
  parameter int unsigned PDL_MS      = 50,
  parameter int unsigned WALL_MS     = 30,
  parameter int unsigned SCORE_MS    = 250,
  parameter int unsigned OVER_MS     = 200,
  parameter int unsigned GAP_MS      = 10
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       evt_paddle,
  input  logic       evt_wall,
  input  logic       evt_score,
  input  logic       evt_over,
  input  logic       mute,
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] active_id
);

  localparam int HALF_W = 17;
  localparam int PRE_W  = 15;
  localparam int MS_W   = 9;

  localparam logic [HALF_W-1:0] PDL_H   = HALF_W'(PDL_HALF);
  localparam logic [HALF_W-1:0] WALL_H  = HALF_W'(WALL_HALF);
  localparam logic [HALF_W-1:0] SCORE_H = HALF_W'(SCORE_HALF);
  localparam logic [HALF_W-1:0] OVER_H0 = HALF_W'(OVER_HALF0);
  localparam logic [HALF_W-1:0] OVER_H1 = HALF_W'(OVER_HALF1);
  localparam logic [HALF_W-1:0] OVER_H2 = HALF_W'(OVER_HALF2);
  localparam logic [PRE_W-1:0]  TICK_M1 = PRE_W'(TICK_CYCLES - 1);
  localparam logic [MS_W-1:0]   PDL_D   = MS_W'(PDL_MS);
  localparam logic [MS_W-1:0]   WALL_D  = MS_W'(WALL_MS);
  localparam logic [MS_W-1:0]   SCORE_D = MS_W'(SCORE_MS);
  localparam logic [MS_W-1:0]   OVER_D  = MS_W'(OVER_MS);
  localparam logic [MS_W-1:0]   GAP_M1  = MS_W'(GAP_MS - 1);

  localparam logic [1:0] ID_WALL  = 2'd0;
  localparam logic [1:0] ID_PDL   = 2'd1;
  localparam logic [1:0] ID_SCORE = 2'd2;
  localparam logic [1:0] ID_OVER  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          pending_q, pending_d;
  logic [1:0]          active_q, active_d;
  logic [1:0]          note_q, note_d;
  logic [HALF_W-1:0]   half_cnt_q, half_cnt_d;
  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [MS_W-1:0]     ms_cnt_q, ms_cnt_d;
  logic                buzzer_q, buzzer_d;

  logic [3:0]          evt_vec;
  logic [3:0]          clr_mask;
  logic [1:0]          grant_id;
  logic                grant_valid;
  logic                preempt;
  logic                do_grant;
  logic                tick_wrap;
  logic                half_wrap;
  logic                dur_done;
  logic                gap_done;
  logic                more_notes;
  logic [HALF_W-1:0]   cur_half;
  logic [MS_W-1:0]     cur_dur;

  assign evt_vec = {evt_over, evt_score, evt_paddle, evt_wall};

  // Highest set pending bit wins; bit index equals source id.
  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    grant_id = ID_WALL;
    if (pending_q[3])      grant_id = ID_OVER;
    else if (pending_q[2]) grant_id = ID_SCORE;
    else if (pending_q[1]) grant_id = ID_PDL;
  end

  always_comb begin
    cur_half = WALL_H;
    cur_dur  = WALL_D;
    case (active_q)
      ID_PDL:   begin cur_half = PDL_H;   cur_dur = PDL_D;   end
      ID_SCORE: begin cur_half = SCORE_H; cur_dur = SCORE_D; end
      ID_OVER: begin
        cur_dur = OVER_D;
        case (note_q)
          2'd0:    cur_half = OVER_H0;
          2'd1:    cur_half = OVER_H1;
          default: cur_half = OVER_H2;
        endcase
      end
      default: ;
    endcase
  end

  assign grant_valid = |pending_q;
  assign preempt     = (state_q == ST_PLAY) && grant_valid && (grant_id > active_q);
  assign do_grant    = !mute && (((state_q == ST_IDLE) && grant_valid) || preempt);
  assign tick_wrap   = (pre_cnt_q == TICK_M1);
  assign half_wrap   = (half_cnt_q == cur_half - HALF_W'(1));
  // Duration ends on the tick wrap that would make the ms count equal the duration.
  assign dur_done    = tick_wrap && (ms_cnt_q == cur_dur - MS_W'(1));
  assign gap_done    = tick_wrap && (ms_cnt_q == GAP_M1);
  assign more_notes  = (active_q == ID_OVER) && (note_q < 2'd2);
  assign clr_mask    = do_grant ? (4'b0001 << grant_id) : 4'b0000;

  // State register
  always_ff @(posedge clk_0 or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (mute) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (grant_valid) state_d = ST_PLAY;
        ST_PLAY: if (!preempt && dur_done && !more_notes) state_d = ST_GAP;
        ST_GAP:  if (gap_done) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy      = (state_q == ST_PLAY) || (state_q == ST_GAP);
    buzzer    = buzzer_q;
    active_id = active_q;
  end

  // Datapath: pending requests, grant bookkeeping and tone counters.
  always_comb begin
    pending_d  = (pending_q & ~clr_mask) | evt_vec;
    active_d   = active_q;
    note_d     = note_q;
    half_cnt_d = half_cnt_q;
    pre_cnt_d  = pre_cnt_q;
    ms_cnt_d   = ms_cnt_q;
    buzzer_d   = buzzer_q;

    if (mute) begin
      pending_d  = 4'b0000;
      note_d     = 2'd0;
      half_cnt_d = '0;
      pre_cnt_d  = '0;
      ms_cnt_d   = '0;
      buzzer_d   = 1'b0;
    end else if (do_grant) begin
      active_d   = grant_id;
      note_d     = 2'd0;
      half_cnt_d = '0;
      pre_cnt_d  = '0;
      ms_cnt_d   = '0;
      buzzer_d   = 1'b0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          half_cnt_d = half_wrap ? '0 : half_cnt_q + HALF_W'(1);
          buzzer_d   = half_wrap ? ~buzzer_q : buzzer_q;
          pre_cnt_d  = tick_wrap ? '0 : pre_cnt_q + PRE_W'(1);
          ms_cnt_d   = tick_wrap ? ms_cnt_q + MS_W'(1) : ms_cnt_q;
          if (dur_done) begin
            // Both a note advance and GAP entry start from cleared counters.
            half_cnt_d = '0;
            pre_cnt_d  = '0;
            ms_cnt_d   = '0;
            buzzer_d   = 1'b0;
            if (more_notes) note_d = note_q + 2'd1;
          end
        end
        ST_GAP: begin
          buzzer_d   = 1'b0;
          pre_cnt_d  = tick_wrap ? '0 : pre_cnt_q + PRE_W'(1);
          ms_cnt_d   = tick_wrap ? ms_cnt_q + MS_W'(1) : ms_cnt_q;
          if (gap_done) begin
            pre_cnt_d = '0;
            ms_cnt_d  = '0;
          end
        end
        default: begin
          half_cnt_d = '0;
          pre_cnt_d  = '0;
          ms_cnt_d   = '0;
          buzzer_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      pending_q  <= 4'b0000;
      active_q   <= ID_WALL;
      note_q     <= 2'd0;
      half_cnt_q <= '0;
      pre_cnt_q  <= '0;
      ms_cnt_q   <= '0;
      buzzer_q   <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      active_q   <= active_d;
      note_q     <= note_d;
      half_cnt_q <= half_cnt_d;
      pre_cnt_q  <= pre_cnt_d;
      ms_cnt_q   <= ms_cnt_d;
      buzzer_q   <= buzzer_d;
    end
  end

endmodule

// File: tb/tb_tone_arbiter.sv
// Directed bench for tone_arbiter with shrunk tick and half-periods so every
// tone, note sequence and gap can be checked cycle by cycle.
module tb_tone_arbiter;

  localparam int TICK  = 8;
  localparam int PDL_H = 3;
  localparam int WAL_H = 5;
  localparam int SCR_H = 2;
  localparam int OV_H0 = 2;
  localparam int OV_H1 = 3;
  localparam int OV_H2 = 4;
  localparam int PDL_L = 4 * TICK;
  localparam int WAL_L = 3 * TICK;
  localparam int SCR_L = 5 * TICK;
  localparam int OV_L  = 2 * TICK;
  localparam int GAP_L = 2 * TICK;

  logic       clk_0 = 1'b0;
  logic       rst;
  logic       evt_paddle, evt_wall, evt_score, evt_over, mute;
  logic       buzzer, busy;
  logic [1:0] active_id;

  int n_checks = 0;
  int n_errors = 0;

  tone_arbiter #(
    .TICK_CYCLES(TICK),
    .PDL_HALF   (PDL_H),
    .WALL_HALF  (WAL_H),
    .SCORE_HALF (SCR_H),
    .OVER_HALF0 (OV_H0),
    .OVER_HALF1 (OV_H1),
    .OVER_HALF2 (OV_H2),
    .PDL_MS     (4),
    .WALL_MS    (3),
    .SCORE_MS   (5),
    .OVER_MS    (2),
    .GAP_MS     (2)
  ) dut (
    .clk_0     (clk_0),
    .rst       (rst),
    .evt_paddle(evt_paddle),
    .evt_wall  (evt_wall),
    .evt_score (evt_score),
    .evt_over  (evt_over),
    .mute      (mute),
    .buzzer    (buzzer),
    .busy      (busy),
    .active_id (active_id)
  );

  always #5 clk_0 = ~clk_0;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_0);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // v = {over, score, paddle, wall}, high for exactly one rising edge.
  task automatic pulse(input logic [3:0] v);
    {evt_over, evt_score, evt_paddle, evt_wall} = v;
    cyc(1);
    {evt_over, evt_score, evt_paddle, evt_wall} = 4'b0000;
  endtask

  // Checks {active_id, busy, buzzer} from cycle 'start' of a tone of 'len'
  // cycles, then optionally the silent gap that follows.
  task automatic run_tone(input string tag, input logic [1:0] id, input int half,
                          input int start, input int len, input bit with_gap);
    for (int i = start; i < len; i++) begin
      check(tag, {4'b0, active_id, busy, buzzer}, {4'b0, id, 1'b1, 1'((i / half) % 2)});
      cyc(1);
    end
    if (with_gap) begin
      for (int i = 0; i < GAP_L; i++) begin
        check({tag, "_gap"}, {4'b0, active_id, busy, buzzer}, {4'b0, id, 2'b10});
        cyc(1);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    mute = 1'b0;
    {evt_over, evt_score, evt_paddle, evt_wall} = 4'b0000;
    cyc(2);
    check("reset_hold", {4'b0, active_id, busy, buzzer}, 8'h00);
    rst = 1'b1;
    cyc(1);
    check("reset_release", {4'b0, active_id, busy, buzzer}, 8'h00);

    // Single paddle tone: pending one edge, PLAY the next.
    pulse(4'b0010);
    check("pdl_lat1", {7'b0, busy}, 8'h00);
    cyc(1);
    run_tone("pdl", 2'd1, PDL_H, 0, PDL_L, 1'b1);
    check("pdl_done", {4'b0, active_id, busy, buzzer}, {4'b0, 2'd1, 2'b00});
    cyc(1);

    // Simultaneous wall + score: score first, then wall after the gap.
    pulse(4'b0101);
    cyc(1);
    run_tone("scr_a", 2'd2, SCR_H, 0, SCR_L, 1'b1);
    check("scr_a_idle", {4'b0, active_id, busy, buzzer}, {4'b0, 2'd2, 2'b00});
    cyc(1);
    run_tone("wal_a", 2'd0, WAL_H, 0, WAL_L, 1'b1);
    check("wal_a_done", {4'b0, active_id, busy, buzzer}, 8'h00);
    cyc(1);

    // Paddle preempted by score part way through; paddle is not resumed.
    pulse(4'b0010);
    cyc(1);
    run_tone("pdl_p", 2'd1, PDL_H, 0, 20, 1'b0);
    pulse(4'b0100);
    check("pre_wait", {4'b0, active_id, busy, buzzer}, {4'b0, 2'd1, 2'b11});
    cyc(1);
    run_tone("scr_p", 2'd2, SCR_H, 0, SCR_L, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("no_resume", {7'b0, busy}, 8'h00);
      cyc(1);
    end

    // Game over: three notes back to back; paddle during note 1 waits.
    pulse(4'b1000);
    cyc(1);
    run_tone("over0", 2'd3, OV_H0, 0, OV_L, 1'b0);
    run_tone("over1a", 2'd3, OV_H1, 0, 5, 1'b0);
    pulse(4'b0010);
    run_tone("over1b", 2'd3, OV_H1, 6, OV_L, 1'b0);
    run_tone("over2", 2'd3, OV_H2, 0, OV_L, 1'b1);
    check("over_idle", {4'b0, active_id, busy, buzzer}, {4'b0, 2'd3, 2'b00});
    cyc(1);
    run_tone("pdl_late", 2'd1, PDL_H, 0, PDL_L, 1'b1);
    check("pdl_late_done", {7'b0, busy}, 8'h00);

    // Pulse held across its own grant edge: bit re-sets, tone replays.
    {evt_over, evt_score, evt_paddle, evt_wall} = 4'b0010;
    cyc(2);
    {evt_over, evt_score, evt_paddle, evt_wall} = 4'b0000;
    run_tone("pdl_r1", 2'd1, PDL_H, 0, PDL_L, 1'b1);
    check("pdl_r_idle", {7'b0, busy}, 8'h00);
    cyc(1);
    run_tone("pdl_r2", 2'd1, PDL_H, 0, PDL_L, 1'b1);
    check("pdl_r_done", {7'b0, busy}, 8'h00);

    // Mute mid-score with wall pending; events under mute are dropped.
    pulse(4'b0100);
    cyc(1);
    run_tone("scr_m", 2'd2, SCR_H, 0, 10, 1'b0);
    pulse(4'b0001);
    mute = 1'b1;
    cyc(1);
    check("mute_now", {4'b0, active_id, busy, buzzer}, {4'b0, 2'd2, 2'b00});
    pulse(4'b0010);
    pulse(4'b1000);
    cyc(1);
    mute = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("mute_after", {4'b0, active_id, busy, buzzer}, {4'b0, 2'd2, 2'b00});
      cyc(1);
    end

    // Asynchronous reset in the middle of a wall tone, then a fresh wall tone.
    pulse(4'b0001);
    cyc(1);
    run_tone("wal_r", 2'd0, WAL_H, 0, 7, 1'b0);
    check("wal_r_high", {7'b0, buzzer}, 8'h01);
    #1 rst = 1'b0;
    #1 check("rst_async", {4'b0, active_id, busy, buzzer}, 8'h00);
    cyc(2);
    rst = 1'b1;
    cyc(2);
    check("rst_after", {4'b0, active_id, busy, buzzer}, 8'h00);
    pulse(4'b0001);
    cyc(1);
    run_tone("wal_b", 2'd0, WAL_H, 0, WAL_L, 1'b1);
    check("wal_b_done", {4'b0, active_id, busy, buzzer}, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
